// File: rtl/teclado_ctrl_exc3_if.sv
// Code delivery handshake between the keypad controller and its consumer.
interface teclado_ctrl_exc3_if;
  logic [3:0] code_out;
  logic       code_valid;
  logic       code_ready;

  modport master (output code_out, output code_valid, input code_ready);
  modport slave  (input code_out, input code_valid, output code_ready);
endinterface

// File: rtl/teclado_ctrl_exc3.sv
// Debounced 10-key keypad to excess-3 encoder with valid/ready delivery.
// TECLADO_BUF_EN: 4-entry FWFT FIFO instead of a single output register.
module teclado_ctrl_exc3 #(
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [9:0]                 key_in,
  teclado_ctrl_exc3_if.master        code_if,
  output logic                       err,
  output logic                       overrun,
  output logic                       busy
);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, EMIT, WAIT_REL} state_t;

  localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

  state_t     state_q;
  logic [9:0] sync1_q, key_s_q, key_cap_q;
  logic [7:0] db_cnt_q, rel_cnt_q;
  logic [7:0] db_cnt_d, rel_cnt_d;
  logic       push_q;
  logic [3:0] push_code_q;
  logic       err_q;
  logic       ovr_q;
  logic [3:0] cap_idx;
  logic       cap_onehot;

  assign db_cnt_d  = db_cnt_q + 8'd1;
  assign rel_cnt_d = rel_cnt_q + 8'd1;

  always_comb begin
    cap_idx    = '0;
    cap_onehot = $onehot(key_cap_q);
    for (int unsigned k = 0; k < 10; k++) begin
      if (key_cap_q[k]) cap_idx = 4'(k);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sync1_q     <= '0;
      key_s_q     <= '0;
      key_cap_q   <= '0;
      db_cnt_q    <= '0;
      rel_cnt_q   <= '0;
      push_q      <= 1'b0;
      push_code_q <= '0;
      err_q       <= 1'b0;
    end else begin
      sync1_q <= key_in;
      key_s_q <= sync1_q;
      push_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (key_s_q != '0) begin
            key_cap_q <= key_s_q;
            db_cnt_q  <= '0;
            state_q   <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (key_s_q == '0) begin
            state_q <= IDLE;
          end else if (key_s_q != key_cap_q) begin
            key_cap_q <= key_s_q;
            db_cnt_q  <= '0;
          end else begin
            db_cnt_q <= db_cnt_d;
            if (db_cnt_d == DB_LAST) state_q <= EMIT;
          end
        end
        EMIT: begin
          // push is registered here and lands in storage on the next edge
          if (cap_onehot) begin
            push_q      <= 1'b1;
            push_code_q <= cap_idx + 4'd3;
          end else begin
            err_q <= 1'b1;
          end
          rel_cnt_q <= '0;
          state_q   <= WAIT_REL;
        end
        WAIT_REL: begin
          if (key_s_q != '0) begin
            rel_cnt_q <= '0;
          end else if (rel_cnt_q == DB_LAST) begin
            state_q <= IDLE;
          end else begin
            rel_cnt_q <= rel_cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef TECLADO_BUF_EN
  logic [3:0] mem_q [4];
  logic [1:0] rd_q, wr_q;
  logic [2:0] cnt_q;
  logic       pop, full, wr_ok;

  assign pop   = (cnt_q != 3'd0) && code_if.code_ready;
  assign full  = (cnt_q == 3'd4);
  assign wr_ok = push_q && (!full || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      ovr_q <= push_q && full && !pop;
      if (wr_ok) begin
        mem_q[wr_q] <= push_code_q;
        wr_q        <= wr_q + 2'd1;
      end
      if (pop) rd_q <= rd_q + 2'd1;
      case ({wr_ok, pop})
        2'b10:   cnt_q <= cnt_q + 3'd1;
        2'b01:   cnt_q <= cnt_q - 3'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign code_if.code_out   = mem_q[rd_q];
  assign code_if.code_valid = (cnt_q != 3'd0);
`else
  logic [3:0] code_q;
  logic       valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (push_q) begin
        if (!valid_q || code_if.code_ready) begin
          code_q  <= push_code_q;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && code_if.code_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign code_if.code_out   = code_q;
  assign code_if.code_valid = valid_q;
`endif

  assign err     = err_q;
  assign overrun = ovr_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: doc/teclado_ctrl_exc3.md
TECLADO_CTRL_EXC3 -- requirements
Module: teclado_ctrl_exc3

Interface
REQ-001 Parameter DB_CYCLES, default 16: consecutive stable synchronized samples required to accept a press or a release (legal range 2..255).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 key_in  input  10  raw one-hot keypad lines, bit k = key k (0..9); asynchronous to clk.
REQ-005 code_out  output  4  excess-3 code of the accepted key (key k -> k+3).
REQ-006 code_valid  output  1  code_out holds an undelivered code.
REQ-007 code_ready  input  1  consumer accepts code_out; transfer occurs when code_valid && code_ready at a rising edge.
REQ-008 err  output  1  one-cycle pulse: a debounced non-one-hot pattern (two or more keys) was rejected.
REQ-009 overrun  output  1  one-cycle pulse: an accepted code was dropped for lack of storage.
REQ-010 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 key_in SHALL pass through a 2-flop synchronizer; the FSM sees only key_s (second stage).
REQ-012 FSM states SHALL be IDLE, DEBOUNCE, EMIT, WAIT_REL.
REQ-013 IDLE: key_s != 0 -> capture key_s into key_cap, clear db_cnt, go to DEBOUNCE.
REQ-014 DEBOUNCE: key_s == 0 -> IDLE, no output; key_s != key_cap -> recapture, clear db_cnt, stay; key_s == key_cap -> db_cnt+1; db_cnt == DB_CYCLES-1 -> EMIT.
REQ-015 EMIT (one cycle): key_cap one-hot -> push code; key_cap not one-hot -> pulse err, push nothing; always go to WAIT_REL.
REQ-016 WAIT_REL: return to IDLE only after key_s == 0 for DB_CYCLES consecutive cycles; any nonzero sample clears the release counter; no codes are generated while in WAIT_REL (one code per press, no auto-repeat).
REQ-017 Latency: with key_in stable from edge 0, code_valid SHALL rise at edge DB_CYCLES+4 (2 sync + 1 IDLE capture + DB_CYCLES-1 debounce + 1 EMIT + register), when storage is available.
REQ-018 code_out and code_valid SHALL be registered and SHALL remain stable while code_valid && !code_ready.
REQ-019 Excess-3 mapping SHALL be key0..key9 -> 4'h3..4'hC; no other value ever appears on code_out while code_valid is high.
REQ-020 Push while storage full and no transfer in the same cycle -> code dropped, overrun pulses, stored code unchanged.
REQ-021 Push and transfer in the same cycle with storage full -> both occur, no overrun.
REQ-022 code_ready while code_valid is low SHALL have no effect.

Reset
REQ-023 rst SHALL force, asynchronously: FSM IDLE, synchronizer, key_cap, counters and storage cleared; code_out=0, code_valid=0, err=0, overrun=0, busy=0.
REQ-024 Reset asserted mid-debounce or mid-handshake SHALL discard the pending code; after release, a key still held SHALL be treated as a new press.

Configuration
REQ-025 Macro TECLADO_BUF_EN: when defined, storage SHALL be a 4-entry first-word-fall-through FIFO (code_valid = not empty, code_out = head, overrun only when 4 entries are held).
REQ-026 TECLADO_BUF_EN undefined: storage SHALL be a single output register (overrun when one code is held and not transferred in the push cycle); behaviour is otherwise identical.

Verification (DB_CYCLES=4)
REQ-027 key_in=10'h004 held 20 cycles, code_ready=1 -> code_valid high at edge 8 for 1 cycle, code_out=4'h5; exactly one transfer.
REQ-028 key_in=10'h001 with 2-cycle glitches to 0 every 3 cycles for 30 cycles -> no code_valid, busy toggles, err=0.
REQ-029 key_in=10'h0C0 held 20 cycles -> err one pulse, code_valid stays 0, then release -> IDLE.
REQ-030 code_ready=0, presses key9, key2, key7 (each released) -> without TECLADO_BUF_EN: code_out=4'hC held, two overrun pulses; with it: FIFO yields C, 5, A in order once ready=1, no overrun.
REQ-031 key_in=10'h200 held, rst pulsed at edge 5 -> all outputs 0 immediately; code 4'hC appears at edge DB_CYCLES+4 after rst deasserts.
REQ-032 FIFO full (TECLADO_BUF_EN), fifth push in the same cycle as code_ready=1 -> no overrun, order preserved.
